// File: rtl/fifo_noc2nic.sv
// ---------------------------------------------------------------------------
// fifo_noc2nic
// Receive-side buffer between a router ejection link and the NIC master-side
// packet builder. Incoming flits are steered by their VC id field into one
// FIFO per virtual channel. Every flit the NIC drains returns one credit to
// the upstream router; draining a tail flit also releases the VC upstream.
//
// Ports
//   clk               clock, all state on rising edge
//   rst               asynchronous active-low reset
//   in_link_i         flit from router link
//   is_valid_i        in_link_i carries a valid flit this cycle
//   credit_signal_o   per-VC credit return pulse (cycle after an accepted pop)
//   free_signal_o     per-VC release pulse (accompanies credit of a tail flit)
//   rd_vc_i           VC selected for read/pop
//   pop_i             pop head flit of FIFO[rd_vc_i]
//   flit_o            head flit of FIFO[rd_vc_i], combinational from storage
//   flit_valid_o      per-VC FIFO non-empty
//   packet_ready_o    per-VC FIFO holds at least one tail flit
//   overflow_error_o  sticky: write to a full FIFO or to an illegal VC id
// ---------------------------------------------------------------------------
module fifo_noc2nic #(
    parameter int FLIT_WIDTH   = 32,
    parameter int N_TOT_OF_VC  = 6,
    parameter int N_BITS_VC    = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int N_BITS_DEPTH = 2,
    parameter int VC_ID_LSB    = 0,
    parameter int TAIL_BIT     = FLIT_WIDTH - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  in_link_i,
    input  logic                   is_valid_i,
    output logic [N_TOT_OF_VC-1:0] credit_signal_o,
    output logic [N_TOT_OF_VC-1:0] free_signal_o,
    input  logic [N_BITS_VC-1:0]   rd_vc_i,
    input  logic                   pop_i,
    output logic [FLIT_WIDTH-1:0]  flit_o,
    output logic [N_TOT_OF_VC-1:0] flit_valid_o,
    output logic [N_TOT_OF_VC-1:0] packet_ready_o,
    output logic                   overflow_error_o
);

    localparam logic [N_BITS_DEPTH:0] FULL_CNT = (N_BITS_DEPTH + 1)'(FIFO_DEPTH);

    logic [N_BITS_VC-1:0]   wr_vc;
    logic [N_TOT_OF_VC-1:0] wr_en;
    logic [N_TOT_OF_VC-1:0] pop_en;
    logic [N_TOT_OF_VC-1:0] pop_tail;
    logic [FLIT_WIDTH-1:0]  head_flit [N_TOT_OF_VC];

    assign wr_vc = in_link_i[VC_ID_LSB +: N_BITS_VC];

    for (genvar v = 0; v < N_TOT_OF_VC; v++) begin : g_vc
        localparam logic [N_BITS_VC-1:0] VC_ID = N_BITS_VC'(v);

        logic [FLIT_WIDTH-1:0]   mem [FIFO_DEPTH];
        logic [N_BITS_DEPTH-1:0] wr_ptr;
        logic [N_BITS_DEPTH-1:0] rd_ptr;
        logic [N_BITS_DEPTH:0]   count;
        logic [N_BITS_DEPTH:0]   tail_cnt;
        logic                    tail_inc;
        logic                    tail_dec;

        // Full check uses this cycle's count, so a write into a full FIFO is
        // rejected even when a pop frees a slot in the same cycle.
        assign wr_en[v]    = is_valid_i && (wr_vc == VC_ID) && (count != FULL_CNT);
        assign pop_en[v]   = pop_i && (rd_vc_i == VC_ID) && (count != '0);
        assign head_flit[v] = mem[rd_ptr];
        assign pop_tail[v] = mem[rd_ptr][TAIL_BIT];
        assign tail_inc    = wr_en[v] && in_link_i[TAIL_BIT];
        assign tail_dec    = pop_en[v] && pop_tail[v];

        assign flit_valid_o[v]   = (count != '0);
        assign packet_ready_o[v] = (tail_cnt != '0);

        // NOTE: flit storage has no reset; pointers and counters alone define
        // what is valid, and leaving the array unreset lets it map to RAM.
        always_ff @(posedge clk) begin
            if (wr_en[v]) begin
                mem[wr_ptr] <= in_link_i;
            end
        end

        // NOTE: all state updates use non-blocking assignments so every
        // counter sees the pre-edge values of its neighbours.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                tail_cnt <= '0;
            end else begin
                if (wr_en[v]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_en[v]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({wr_en[v], pop_en[v]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                case ({tail_inc, tail_dec})
                    2'b10:   tail_cnt <= tail_cnt + 1'b1;
                    2'b01:   tail_cnt <= tail_cnt - 1'b1;
                    default: tail_cnt <= tail_cnt;
                endcase
            end
        end
    end

    // NOTE: the read mux gets a default before the loop so no path through
    // the block leaves flit_o unassigned (no latch).
    always_comb begin
        flit_o = head_flit[0];
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            if (rd_vc_i == N_BITS_VC'(v)) begin
                flit_o = head_flit[v];
            end
        end
    end

    // Credit and release pulses are registered copies of the accepted pop;
    // only one VC can be popped per cycle, so each output is one-hot or zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_signal_o  <= '0;
            free_signal_o    <= '0;
            overflow_error_o <= 1'b0;
        end else begin
            credit_signal_o <= pop_en;
            free_signal_o   <= pop_en & pop_tail;
            // Any valid flit not accepted by some FIFO was either aimed at a
            // full FIFO or carried an out-of-range VC id.
            if (is_valid_i && (wr_en == '0)) begin
                overflow_error_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_noc2nic.sv
// ---------------------------------------------------------------------------
// tb_fifo_noc2nic
// Self-checking bench for fifo_noc2nic. A reference model keeps each VC as an
// ordered list of buffered flits; credits, releases, valid/ready flags and
// the sticky error are derived from that list.
// ---------------------------------------------------------------------------
module tb_fifo_noc2nic;

    localparam int FW    = 32;
    localparam int NVC   = 6;
    localparam int DEPTH = 4;

    logic           clk;
    logic           rst;
    logic [FW-1:0]  in_link_i;
    logic           is_valid_i;
    logic [NVC-1:0] credit_signal_o;
    logic [NVC-1:0] free_signal_o;
    logic [2:0]     rd_vc_i;
    logic           pop_i;
    logic [FW-1:0]  flit_o;
    logic [NVC-1:0] flit_valid_o;
    logic [NVC-1:0] packet_ready_o;
    logic           overflow_error_o;

    fifo_noc2nic dut (
        .clk              (clk),
        .rst              (rst),
        .in_link_i        (in_link_i),
        .is_valid_i       (is_valid_i),
        .credit_signal_o  (credit_signal_o),
        .free_signal_o    (free_signal_o),
        .rd_vc_i          (rd_vc_i),
        .pop_i            (pop_i),
        .flit_o           (flit_o),
        .flit_valid_o     (flit_valid_o),
        .packet_ready_o   (packet_ready_o),
        .overflow_error_o (overflow_error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per-VC list of buffered flits, oldest at index 0.
    logic [FW-1:0]  mq   [NVC][DEPTH];
    int             mcnt [NVC];
    logic           exp_ovf;
    logic [NVC-1:0] exp_credit;
    logic [NVC-1:0] exp_free;
    logic           exp_pop_ok;
    logic [FW-1:0]  exp_popped;
    logic [FW-1:0]  seen_flit;

    function automatic logic [FW-1:0] mk_flit(input logic tail, input logic [2:0] vc);
        logic [31:0] r;
        r = $urandom;
        return {tail, r[27:0], vc};
    endfunction

    function automatic logic [NVC-1:0] model_valid();
        logic [NVC-1:0] m;
        for (int v = 0; v < NVC; v++) m[v] = (mcnt[v] > 0);
        return m;
    endfunction

    function automatic logic [NVC-1:0] model_ready();
        logic [NVC-1:0] m;
        m = '0;
        for (int v = 0; v < NVC; v++)
            for (int i = 0; i < mcnt[v]; i++)
                if (mq[v][i][FW-1]) m[v] = 1'b1;
        return m;
    endfunction

    task automatic model_clear();
        for (int v = 0; v < NVC; v++) mcnt[v] = 0;
        exp_ovf    = 1'b0;
        exp_credit = '0;
        exp_free   = '0;
    endtask

    // One clock cycle of stimulus; updates the model and returns at the
    // following negedge with outputs settled.
    task automatic do_cycle(input logic valid, input logic [FW-1:0] flit,
                            input logic [2:0] vc, input logic pop);
        int  wv;
        bit  w_ok;
        in_link_i  = flit;
        is_valid_i = valid;
        rd_vc_i    = vc;
        pop_i      = pop;
        #1;
        seen_flit  = flit_o;
        wv   = int'(flit[2:0]);
        w_ok = valid && (wv < NVC) && (mcnt[wv] < DEPTH);
        if (valid && !w_ok) exp_ovf = 1'b1;
        exp_credit = '0;
        exp_free   = '0;
        exp_pop_ok = pop && (int'(vc) < NVC) && (mcnt[vc] > 0);
        if (exp_pop_ok) begin
            exp_popped     = mq[vc][0];
            exp_credit[vc] = 1'b1;
            exp_free[vc]   = exp_popped[FW-1];
            for (int i = 0; i < DEPTH - 1; i++) mq[vc][i] = mq[vc][i+1];
            mcnt[vc]--;
        end
        if (w_ok) begin
            mq[wv][mcnt[wv]] = flit;
            mcnt[wv]++;
        end
        @(posedge clk);
        @(negedge clk);
        is_valid_i = 1'b0;
        pop_i      = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        is_valid_i = 1'b0;
        pop_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [FW-1:0] f;
        f = mk_flit(1'b1, 3'd4);
        do_cycle(1'b1, f, 3'd0, 1'b0);
        do_cycle(1'b1, mk_flit(1'b0, 3'd7), 3'd4, 1'b1);
        // Credit for VC4 and the error are both pending here.
        total++;
        if (credit_signal_o !== 6'b010000 || overflow_error_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre: credit=%b ovf=%b want credit=010000 ovf=1",
                     credit_signal_o, overflow_error_o);
        end
        do_cycle(1'b1, mk_flit(1'b0, 3'd1), 3'd0, 1'b0);
        rst = 1'b0;
        #1;
        total++;
        if (credit_signal_o !== '0 || free_signal_o !== '0 || flit_valid_o !== '0 ||
            packet_ready_o !== '0 || overflow_error_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: cr=%b fr=%b fv=%b pr=%b ovf=%b want all 0",
                     credit_signal_o, free_signal_o, flit_valid_o, packet_ready_o, overflow_error_o);
        end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, '0, 3'd1, 1'b1);
            total++;
            if (flit_valid_o !== '0 || credit_signal_o !== '0) begin
                bad++;
                $display("FAIL reset_after: fv=%b cr=%b want 0 0", flit_valid_o, credit_signal_o);
            end
        end
    endtask

    task automatic test_single();
        logic [FW-1:0] f;
        f = mk_flit(1'b1, 3'd2);
        do_cycle(1'b1, f, 3'd0, 1'b0);
        total++;
        if (flit_valid_o !== 6'b000100 || packet_ready_o !== 6'b000100) begin
            bad++;
            $display("FAIL single_flags: fv=%b pr=%b want 000100 000100", flit_valid_o, packet_ready_o);
        end
        do_cycle(1'b0, '0, 3'd2, 1'b1);
        total++;
        if (seen_flit !== f) begin
            bad++;
            $display("FAIL single_data: got=%h want=%h", seen_flit, f);
        end
        total++;
        if (credit_signal_o !== 6'b000100 || free_signal_o !== 6'b000100) begin
            bad++;
            $display("FAIL single_credit: cr=%b fr=%b want 000100 000100", credit_signal_o, free_signal_o);
        end
        do_cycle(1'b0, '0, 3'd2, 1'b0);
        total++;
        if (credit_signal_o !== '0 || flit_valid_o !== '0) begin
            bad++;
            $display("FAIL single_idle: cr=%b fv=%b want 0 0", credit_signal_o, flit_valid_o);
        end
    endtask

    task automatic test_packet();
        logic [FW-1:0] pk [3];
        pk[0] = mk_flit(1'b0, 3'd0);
        pk[1] = mk_flit(1'b0, 3'd0);
        pk[2] = mk_flit(1'b1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, pk[i], 3'd0, 1'b0);
            total++;
            if (packet_ready_o[0] !== (i == 2)) begin
                bad++;
                $display("FAIL packet_ready%0d: got=%b want=%b", i, packet_ready_o[0], (i == 2));
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, '0, 3'd0, 1'b1);
            total++;
            if (seen_flit !== pk[i] || credit_signal_o !== 6'b000001 ||
                free_signal_o !== ((i == 2) ? 6'b000001 : 6'b000000)) begin
                bad++;
                $display("FAIL packet_pop%0d: flit=%h cr=%b fr=%b want flit=%h cr=000001 fr_tail=%0d",
                         i, seen_flit, credit_signal_o, free_signal_o, pk[i], (i == 2));
            end
        end
    endtask

    task automatic test_overflow();
        logic [FW-1:0] fl [5];
        for (int i = 0; i < 5; i++) begin
            fl[i] = mk_flit(i[0], 3'd5);
            do_cycle(1'b1, fl[i], 3'd0, 1'b0);
            total++;
            if (overflow_error_o !== (i == 4)) begin
                bad++;
                $display("FAIL ovf_write%0d: got=%b want=%b", i, overflow_error_o, (i == 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, '0, 3'd5, 1'b1);
            total++;
            if (seen_flit !== fl[i] || credit_signal_o !== 6'b100000) begin
                bad++;
                $display("FAIL ovf_pop%0d: flit=%h cr=%b want flit=%h cr=100000",
                         i, seen_flit, credit_signal_o, fl[i]);
            end
        end
        total++;
        if (overflow_error_o !== 1'b1 || flit_valid_o !== '0) begin
            bad++;
            $display("FAIL ovf_sticky: ovf=%b fv=%b want 1 000000", overflow_error_o, flit_valid_o);
        end
    endtask

    task automatic test_simultaneous();
        do_cycle(1'b1, mk_flit(1'b0, 3'd1), 3'd0, 1'b0);
        do_cycle(1'b1, mk_flit(1'b1, 3'd1), 3'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b1, mk_flit(logic'($urandom_range(0, 1)), 3'd1), 3'd1, 1'b1);
            total++;
            if (seen_flit !== exp_popped || credit_signal_o !== 6'b000010 ||
                flit_valid_o !== 6'b000010 || packet_ready_o !== model_ready() ||
                overflow_error_o !== 1'b0) begin
                bad++;
                $display("FAIL simul%0d: flit=%h cr=%b fv=%b pr=%b ovf=%b want flit=%h cr=000010 fv=000010 pr=%b ovf=0",
                         i, seen_flit, credit_signal_o, flit_valid_o, packet_ready_o,
                         overflow_error_o, exp_popped, model_ready());
            end
        end
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b0, '0, 3'd1, 1'b1);
            total++;
            if (seen_flit !== exp_popped || flit_valid_o !== model_valid()) begin
                bad++;
                $display("FAIL simul_drain%0d: flit=%h fv=%b want flit=%h fv=%b",
                         i, seen_flit, flit_valid_o, exp_popped, model_valid());
            end
        end
        // Full FIFO with write+pop: the write must still be rejected.
        for (int i = 0; i < 4; i++) do_cycle(1'b1, mk_flit(1'b0, 3'd1), 3'd0, 1'b0);
        do_cycle(1'b1, mk_flit(1'b1, 3'd1), 3'd1, 1'b1);
        total++;
        if (overflow_error_o !== 1'b1 || credit_signal_o !== 6'b000010 || packet_ready_o !== 6'b000000) begin
            bad++;
            $display("FAIL full_simul: ovf=%b cr=%b pr=%b want 1 000010 000000",
                     overflow_error_o, credit_signal_o, packet_ready_o);
        end
    endtask

    task automatic test_illegal();
        do_cycle(1'b0, '0, 3'd3, 1'b1);
        total++;
        if (credit_signal_o !== '0 || flit_valid_o !== '0 || overflow_error_o !== 1'b0) begin
            bad++;
            $display("FAIL pop_empty: cr=%b fv=%b ovf=%b want 0 0 0", credit_signal_o, flit_valid_o, overflow_error_o);
        end
        do_cycle(1'b1, mk_flit(1'b1, 3'd7), 3'd7, 1'b1);
        total++;
        if (overflow_error_o !== 1'b1 || flit_valid_o !== '0 || credit_signal_o !== '0) begin
            bad++;
            $display("FAIL vc7: ovf=%b fv=%b cr=%b want 1 0 0", overflow_error_o, flit_valid_o, credit_signal_o);
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 2; round++) begin
            apply_reset();
            for (int i = 0; i < 200; i++) begin
                logic [2:0] wvc;
                logic [2:0] rvc;
                wvc = ($urandom_range(0, 29) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
                rvc = 3'($urandom_range(0, 6));
                do_cycle(logic'($urandom_range(0, 2) != 0), mk_flit(logic'($urandom_range(0, 1)), wvc),
                         rvc, logic'($urandom_range(0, 1)));
                if (exp_pop_ok) begin
                    total++;
                    if (seen_flit !== exp_popped) begin
                        bad++;
                        $display("FAIL rand_data r%0d c%0d: got=%h want=%h", round, i, seen_flit, exp_popped);
                    end
                end
                total++;
                if (credit_signal_o !== exp_credit || free_signal_o !== exp_free ||
                    flit_valid_o !== model_valid() || packet_ready_o !== model_ready() ||
                    overflow_error_o !== exp_ovf) begin
                    bad++;
                    $display("FAIL rand_state r%0d c%0d: cr=%b fr=%b fv=%b pr=%b ovf=%b want cr=%b fr=%b fv=%b pr=%b ovf=%b",
                             round, i, credit_signal_o, free_signal_o, flit_valid_o, packet_ready_o,
                             overflow_error_o, exp_credit, exp_free, model_valid(), model_ready(), exp_ovf);
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        in_link_i  = '0;
        is_valid_i = 1'b0;
        rd_vc_i    = '0;
        pop_i      = 1'b0;
        model_clear();
        @(negedge clk);
        #1;
        total++;
        if (flit_valid_o !== '0 || credit_signal_o !== '0 || overflow_error_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: fv=%b cr=%b ovf=%b want 0 0 0", flit_valid_o, credit_signal_o, overflow_error_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_packet();
        test_overflow();
        apply_reset();
        test_simultaneous();
        apply_reset();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
